if_id_buf: RTL and testbench
============================

// Module: if_id_buf
// PURPOSE
//  Parametrised IF/ID decoupling stage. Replaces the single-entry IF->ID register with a DEPTH-entry
//  instruction buffer using a valid/ready handshake.
//  Sits between the fetch unit and the decoder. It absorbs decoder stalls without dropping fetched
//  words and empties on a branch/jump flush.
//  Presents NOP to decode whenever it holds no valid entry.
// PARAMETERS
//  INST_W   32             instruction width
//  ADDR_W   32             instruction address width
//  DEPTH    2              buffer entries; power of two, >=2
//  NOP_INST 32'h00000013   word driven on inst_o when no valid entry (addi x0,x0,0)
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  rst          in   1       asynchronous, active-high reset
//  inst_i       in   INST_W  fetched instruction
//  inst_addr_i  in   ADDR_W  address of inst_i
//  inst_valid_i in   1       fetch offers inst_i/inst_addr_i this cycle
//  inst_ready_o out  1       buffer accepts an offer this cycle (push = valid_i & ready_o)
//  flush_i      in   1       discard all buffered and same-cycle offered entries
//  hold_i       in   1       decode stalled; head entry is not consumed
//  inst_o       out  INST_W  head instruction, or NOP_INST when inst_valid_o=0
//  inst_addr_o  out  ADDR_W  head address; when empty, address of the last popped entry
//  inst_valid_o out  1       head entry valid
//  count_o      out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
// BEHAVIOUR
//  - Reset (async assert, released on clk edge): wr_ptr=rd_ptr=0, count=0, last_addr=0.
//    Outputs: inst_o=NOP_INST, inst_addr_o=0, inst_valid_o=0, count_o=0, inst_ready_o=1.
//    Offers are ignored while rst=1. Reset mid-operation drops all entries immediately.
//  - inst_ready_o = (count != DEPTH). Depends on state only; no combinational path from hold_i or flush_i.
//    When full, no push occurs, even on a pop cycle.
//  - inst_valid_o = (count != 0). pop = inst_valid_o & ~hold_i & ~flush_i.
//  - Latency: an entry pushed at edge N is visible on the outputs after edge N (1 cycle).
//    There is no empty-bypass path. Order is strict FIFO.
//  - Push and pop in the same cycle: count unchanged, both pointers advance.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
//  - On pop: last_addr <= head address.
//  - flush_i=1 has priority over push, pop and hold. Next state: count=0, rd_ptr=wr_ptr, no write.
//    last_addr <= head address if valid, else unchanged.
//  - Outputs are combinational from state:
//    inst_o = valid ? mem[rd_ptr].inst : NOP_INST
//    inst_addr_o = valid ? mem[rd_ptr].addr : last_addr
//  - hold_i with an empty buffer has no effect. Pushes continue during hold until full.
//  - No overflow or underflow is possible by construction. Storage contents are not reset.
// STRUCTURE
//  - Shared defines (existing defines header): INST_NOP, ZeroWord, InstBus/InstAddrBus widths,
//    and RstEnable polarity (1'b1).
//  - Sub-module if_id_buf_mem: DEPTH x (INST_W+ADDR_W) register array, one write port, one
//    asynchronous read port, no reset.
//  - Top level holds pointers, count, last_addr and output muxing.
// TESTING
//  1. Reset: assert rst mid-cycle with 2 entries held
//     -> at once valid_o=0, inst_o=32'h13, addr_o=0, count_o=0, ready_o=1.
//  2. Stream: push 0x00500093@0x100 then 0x00A00113@0x104, hold_i=0
//     -> each appears 1 cycle after its push, in order; count_o never exceeds 1.
//  3. Fill/stall: hold_i=1, push 3 words (DEPTH=2)
//     -> ready_o=0 after the 2nd push and the 3rd is not accepted.
//     Release hold -> pops 0x100 then 0x104; ready_o returns to 1 the cycle after the first pop.
//  4. Flush priority: buffer full, flush_i=1 with hold_i=1 and valid_i=1 (0x200)
//     -> next cycle count_o=0, valid_o=0, inst_o=NOP, addr_o=0x100 (old head); 0x200 is not stored.
//  5. Wrap: 10 back-to-back push/pop cycles with DEPTH=4, addresses 0x0..0x24
//     -> output address sequence is exact, with no loss or duplication across pointer wrap.
//  6. Empty hold: after draining (last pop 0x108), idle 3 cycles
//     -> inst_o=NOP, addr_o=0x108 stable, valid_o=0.

Source files
------------

// File: rtl/if_id_buf_pkg.sv
// rtl/if_id_buf_pkg.sv - shared constants for the IF/ID instruction buffer
package if_id_buf_pkg;

    // Default bus widths of the fetch/decode datapath
    localparam int INST_BUS_W      = 32;
    localparam int INST_ADDR_BUS_W = 32;

    // addi x0,x0,0 presented to decode while the buffer is empty
    localparam logic [31:0] INST_NOP  = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Reset level shared across the pipeline
    localparam logic RST_ENABLE = 1'b1;

endpackage

// File: rtl/if_id_buf_if.sv
// rtl/if_id_buf_if.sv - fetch/decode handshake bundle for the IF/ID buffer
interface if_id_buf_if #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) ();

    // Fetch side offer
    logic [INST_W-1:0]        inst_i;
    logic [ADDR_W-1:0]        inst_addr_i;
    logic                     inst_valid_i;
    logic                     inst_ready_o;

    // Pipeline control from decode / branch unit
    logic                     flush_i;
    logic                     hold_i;

    // Decode side head entry
    logic [INST_W-1:0]        inst_o;
    logic [ADDR_W-1:0]        inst_addr_o;
    logic                     inst_valid_o;
    logic [$clog2(DEPTH):0]   count_o;

    // Driver of fetch offers and pipeline control
    modport master (
        output inst_i, inst_addr_i, inst_valid_i, flush_i, hold_i,
        input  inst_ready_o, inst_o, inst_addr_o, inst_valid_o, count_o
    );

    // The buffer itself
    modport slave (
        input  inst_i, inst_addr_i, inst_valid_i, flush_i, hold_i,
        output inst_ready_o, inst_o, inst_addr_o, inst_valid_o, count_o
    );

endinterface

// File: rtl/if_id_buf_mem.sv
// rtl/if_id_buf_mem.sv - entry storage: one write port, async read, no reset
module if_id_buf_mem #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Capture an accepted entry; contents are never cleared
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_buf.sv
// rtl/if_id_buf.sv - DEPTH-entry IF/ID instruction buffer with flush and hold
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int                INST_W   = INST_BUS_W,
    parameter int                ADDR_W   = INST_ADDR_BUS_W,
    parameter int                DEPTH    = 2,
    parameter logic [INST_W-1:0] NOP_INST = INST_NOP
) (
    input  logic      clk,
    input  logic      rst,
    if_id_buf_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    logic [ADDR_W-1:0]        last_addr;
    logic [INST_W+ADDR_W-1:0] head;
    logic [INST_W-1:0]        head_inst;
    logic [ADDR_W-1:0]        head_addr;
    logic                     ready;
    logic                     valid;
    logic                     push;
    logic                     pop;

    // Ready and valid come from state only, so hold/flush never reach ready combinationally
    assign ready = (count != FULL_CNT);
    assign valid = (count != '0);
    assign push  = bus.inst_valid_i & ready & ~bus.flush_i;
    assign pop   = valid & ~bus.hold_i & ~bus.flush_i;

    if_id_buf_mem #(
        .DEPTH (DEPTH),
        .W     (INST_W + ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({bus.inst_i, bus.inst_addr_i}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign head_inst = head[INST_W+ADDR_W-1:ADDR_W];
    assign head_addr = head[ADDR_W-1:0];

    // Pointer/count bookkeeping; flush empties the buffer and wins over push, pop and hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_addr <= '0;
        end else if (bus.flush_i) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
            if (valid) begin
                last_addr <= head_addr;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_addr <= head_addr;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Decode sees NOP and the last consumed address whenever nothing is buffered
    always_comb begin
        bus.inst_o       = valid ? head_inst : NOP_INST;
        bus.inst_addr_o  = valid ? head_addr : last_addr;
        bus.inst_valid_o = valid;
        bus.inst_ready_o = ready;
        bus.count_o      = count;
    end

endmodule

// File: tb/tb_if_id_buf.sv
// tb/tb_if_id_buf.sv - scoreboard bench for if_id_buf (DEPTH=2 and DEPTH=4)
module tb_if_id_buf;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] sb2[$];
    logic [63:0] sb4[$];
    int          m_cnt2 = 0;
    int          m_cnt4 = 0;

    always #5 clk = ~clk;

    if_id_buf_if #(.INST_W(32), .ADDR_W(32), .DEPTH(2)) b2 ();
    if_id_buf_if #(.INST_W(32), .ADDR_W(32), .DEPTH(4)) b4 ();

    if_id_buf #(.INST_W(32), .ADDR_W(32), .DEPTH(2), .NOP_INST(NOP)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    if_id_buf #(.INST_W(32), .ADDR_W(32), .DEPTH(4), .NOP_INST(NOP)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    task automatic cycle2(input logic v, input logic [31:0] ins, input logic [31:0] adr,
                          input logic h, input logic f);
        logic acc;
        logic pp;
        b2.inst_valid_i = v;
        b2.inst_i       = ins;
        b2.inst_addr_i  = adr;
        b2.hold_i       = h;
        b2.flush_i      = f;
        acc = v && (m_cnt2 != 2) && !f;
        pp  = (m_cnt2 != 0) && !h && !f;
        @(posedge clk);
        #1;
        if (f) begin
            sb2.delete();
            m_cnt2 = 0;
        end else begin
            if (pp) begin
                void'(sb2.pop_front());
                m_cnt2 = m_cnt2 - 1;
            end
            if (acc) begin
                sb2.push_back({ins, adr});
                m_cnt2 = m_cnt2 + 1;
            end
        end
        b2.inst_valid_i = 1'b0;
        b2.flush_i      = 1'b0;
    endtask

    task automatic test_reset;
        // state straight out of power-on reset
        checks++;
        if (b2.inst_valid_o !== 1'b0 || b2.inst_o !== NOP || b2.inst_addr_o !== 32'h0 ||
            b2.count_o !== 2'd0 || b2.inst_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL por_state: valid=%b inst=%h addr=%h cnt=%0d rdy=%b, want 0/00000013/0/0/1",
                     b2.inst_valid_o, b2.inst_o, b2.inst_addr_o, b2.count_o, b2.inst_ready_o);
        end
        rst = 1'b0;
        cycle2(1'b1, 32'hAAAA_0001, 32'h40, 1'b1, 1'b0);
        cycle2(1'b1, 32'hAAAA_0002, 32'h44, 1'b1, 1'b0);
        checks++;
        if (b2.count_o !== 2'd2) begin
            errors++;
            $display("FAIL pre_reset_count: got %0d want 2", b2.count_o);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (b2.inst_valid_o !== 1'b0 || b2.inst_o !== NOP || b2.inst_addr_o !== 32'h0 ||
            b2.count_o !== 2'd0 || b2.inst_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: valid=%b inst=%h addr=%h cnt=%0d rdy=%b, want 0/00000013/0/0/1",
                     b2.inst_valid_o, b2.inst_o, b2.inst_addr_o, b2.count_o, b2.inst_ready_o);
        end
        b2.inst_valid_i = 1'b1;
        b2.hold_i       = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (b2.count_o !== 2'd0 || b2.inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL offer_in_reset: cnt=%0d valid=%b want 0/0", b2.count_o, b2.inst_valid_o);
        end
        b2.inst_valid_i = 1'b0;
        sb2.delete();
        m_cnt2 = 0;
        rst = 1'b0;
    endtask

    task automatic test_stream;
        logic [63:0] exp;
        cycle2(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0);
        exp = sb2[0];
        checks++;
        if (b2.inst_valid_o !== 1'b1 || {b2.inst_o, b2.inst_addr_o} !== exp || b2.count_o !== 2'd1) begin
            errors++;
            $display("FAIL stream_first: valid=%b got %h@%h cnt=%0d want %h@%h cnt=1",
                     b2.inst_valid_o, b2.inst_o, b2.inst_addr_o, b2.count_o, exp[63:32], exp[31:0]);
        end
        cycle2(1'b1, 32'h00A0_0113, 32'h104, 1'b0, 1'b0);
        exp = sb2[0];
        checks++;
        if (b2.inst_valid_o !== 1'b1 || {b2.inst_o, b2.inst_addr_o} !== exp || b2.count_o !== 2'd1) begin
            errors++;
            $display("FAIL stream_second: valid=%b got %h@%h cnt=%0d want %h@%h cnt=1",
                     b2.inst_valid_o, b2.inst_o, b2.inst_addr_o, b2.count_o, exp[63:32], exp[31:0]);
        end
        cycle2(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (b2.count_o !== 2'd0 || b2.inst_valid_o !== 1'b0 || b2.inst_addr_o !== 32'h104) begin
            errors++;
            $display("FAIL stream_drain: cnt=%0d valid=%b addr=%h want 0/0/104",
                     b2.count_o, b2.inst_valid_o, b2.inst_addr_o);
        end
    endtask

    task automatic test_fill_stall;
        logic [63:0] exp;
        cycle2(1'b1, 32'h1111_0001, 32'h100, 1'b1, 1'b0);
        checks++;
        if (b2.inst_ready_o !== 1'b1 || b2.count_o !== 2'd1) begin
            errors++;
            $display("FAIL fill_one: rdy=%b cnt=%0d want 1/1", b2.inst_ready_o, b2.count_o);
        end
        cycle2(1'b1, 32'h1111_0002, 32'h104, 1'b1, 1'b0);
        checks++;
        if (b2.inst_ready_o !== 1'b0 || b2.count_o !== 2'd2) begin
            errors++;
            $display("FAIL fill_full: rdy=%b cnt=%0d want 0/2", b2.inst_ready_o, b2.count_o);
        end
        cycle2(1'b1, 32'h1111_0003, 32'h108, 1'b1, 1'b0);
        exp = sb2[0];
        checks++;
        if (b2.count_o !== 2'd2 || {b2.inst_o, b2.inst_addr_o} !== exp || exp[31:0] !== 32'h100) begin
            errors++;
            $display("FAIL fill_reject: cnt=%0d head %h@%h want 2 %h@100",
                     b2.count_o, b2.inst_o, b2.inst_addr_o, exp[63:32]);
        end
        cycle2(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        exp = sb2[0];
        checks++;
        if (b2.inst_ready_o !== 1'b1 || {b2.inst_o, b2.inst_addr_o} !== exp || exp[31:0] !== 32'h104) begin
            errors++;
            $display("FAIL release_pop1: rdy=%b head %h@%h want 1 %h@104",
                     b2.inst_ready_o, b2.inst_o, b2.inst_addr_o, exp[63:32]);
        end
        cycle2(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (b2.count_o !== 2'd0 || b2.inst_addr_o !== 32'h104 || sb2.size() != 0) begin
            errors++;
            $display("FAIL release_pop2: cnt=%0d addr=%h sb=%0d want 0/104/0",
                     b2.count_o, b2.inst_addr_o, sb2.size());
        end
    endtask

    task automatic test_flush;
        cycle2(1'b1, 32'h2222_0001, 32'h100, 1'b1, 1'b0);
        cycle2(1'b1, 32'h2222_0002, 32'h104, 1'b1, 1'b0);
        cycle2(1'b1, 32'h2222_0003, 32'h200, 1'b1, 1'b1);
        checks++;
        if (b2.count_o !== 2'd0 || b2.inst_valid_o !== 1'b0 || b2.inst_o !== NOP ||
            b2.inst_addr_o !== 32'h100 || b2.inst_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_state: cnt=%0d valid=%b inst=%h addr=%h rdy=%b want 0/0/00000013/100/1",
                     b2.count_o, b2.inst_valid_o, b2.inst_o, b2.inst_addr_o, b2.inst_ready_o);
        end
        cycle2(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (b2.count_o !== 2'd0 || b2.inst_valid_o !== 1'b0 || b2.inst_addr_o !== 32'h100) begin
            errors++;
            $display("FAIL flush_no_store: cnt=%0d valid=%b addr=%h want 0/0/100",
                     b2.count_o, b2.inst_valid_o, b2.inst_addr_o);
        end
    endtask

    task automatic test_wrap;
        logic [63:0] exp;
        logic [31:0] want_addr;
        int          popped = 0;
        for (int k = 0; k < 11; k++) begin
            if (b4.inst_valid_o === 1'b1) begin
                want_addr = 32'(popped * 4);
                exp = (sb4.size() != 0) ? sb4.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
                checks++;
                if ({b4.inst_o, b4.inst_addr_o} !== exp || b4.inst_addr_o !== want_addr) begin
                    errors++;
                    $display("FAIL wrap_pop%0d: got %h@%h want %h@%h",
                             popped, b4.inst_o, b4.inst_addr_o, exp[63:32], want_addr);
                end
                popped++;
                m_cnt4 = m_cnt4 - 1;
            end
            if (k < 10) begin
                b4.inst_valid_i = 1'b1;
                b4.inst_i       = 32'hC0DE_0000 + 32'(k);
                b4.inst_addr_i  = 32'(k * 4);
                sb4.push_back({32'hC0DE_0000 + 32'(k), 32'(k * 4)});
                m_cnt4 = m_cnt4 + 1;
            end else begin
                b4.inst_valid_i = 1'b0;
            end
            @(posedge clk);
            #1;
            checks++;
            if (int'(b4.count_o) != m_cnt4) begin
                errors++;
                $display("FAIL wrap_count%0d: got %0d want %0d", k, b4.count_o, m_cnt4);
            end
        end
        checks++;
        if (popped != 10 || b4.inst_addr_o !== 32'h24 || b4.inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_total: popped=%0d addr=%h valid=%b want 10/24/0",
                     popped, b4.inst_addr_o, b4.inst_valid_o);
        end
    endtask

    task automatic test_empty_hold;
        cycle2(1'b1, 32'h3333_0001, 32'h108, 1'b0, 1'b0);
        cycle2(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle2(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            checks++;
            if (b2.inst_o !== NOP || b2.inst_addr_o !== 32'h108 || b2.inst_valid_o !== 1'b0 ||
                b2.count_o !== 2'd0) begin
                errors++;
                $display("FAIL empty_hold%0d: inst=%h addr=%h valid=%b cnt=%0d want 00000013/108/0/0",
                         k, b2.inst_o, b2.inst_addr_o, b2.inst_valid_o, b2.count_o);
            end
        end
    endtask

    initial begin
        b2.inst_i = '0; b2.inst_addr_i = '0; b2.inst_valid_i = 1'b0; b2.hold_i = 1'b0; b2.flush_i = 1'b0;
        b4.inst_i = '0; b4.inst_addr_i = '0; b4.inst_valid_i = 1'b0; b4.hold_i = 1'b0; b4.flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_stream;
        test_fill_stall;
        test_flush;
        test_wrap;
        test_empty_hold;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
